// File: rtl/hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// hdlc_rx_frame_ctrl
//
// Receive-side frame controller for an HDLC datapath. Bytes of an incoming
// frame are written into an internal buffer. On end-of-frame the trailing FCS
// bytes are stripped, and a good frame is held for the CPU, which reads it out
// one byte at a time. Sticky status flags describe the last frame.
//
// Ports
//   Clk              in   single clock, rising edge
//   Rst              in   synchronous reset, active-high
//   Rx_ValidFrame    in   datapath is inside a frame (rising edge = frame start)
//   Rx_WrBuff        in   strobe: Rx_Data holds a received byte
//   Rx_Data[7:0]     in   received byte
//   Rx_EoF           in   end-of-frame pulse
//   Rx_AbortSignal   in   abort-during-frame pulse
//   Rx_FCSerr        in   FCS check result, sampled with Rx_EoF
//   Rd_Req           in   CPU requests the next payload byte
//   Rx_Drop          in   CPU discards the held frame
//   Rd_Data[7:0]     out  payload byte, valid when Rd_Valid=1, else holds
//   Rd_Valid         out  one-cycle read response
//   Rx_Ready         out  a complete good frame is held
//   Rx_FrameSize     out  payload byte count of the held frame
//   Rx_Overflow      out  sticky: bytes lost because the buffer was full
//   Rx_AbortedFrame  out  sticky: last frame was aborted
//   Rx_FrameError    out  sticky: last frame had an FCS error or was too short
//   Rx_Lost          out  sticky: a frame started while a frame was held
//
// Read handshake: Rd_Req is a single-cycle request with no back-pressure. A
// request accepted while a frame is held and unread bytes remain is answered
// by Rd_Valid=1 with Rd_Data exactly one cycle later; any other request (no
// held frame, no bytes left, or together with Rx_Drop) gets no response.
// -----------------------------------------------------------------------------
module hdlc_rx_frame_ctrl #(
  parameter int BUF_DEPTH = 128,
  parameter int FCS_BYTES = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Rx_ValidFrame,
  input  logic                         Rx_WrBuff,
  input  logic [7:0]                   Rx_Data,
  input  logic                         Rx_EoF,
  input  logic                         Rx_AbortSignal,
  input  logic                         Rx_FCSerr,
  input  logic                         Rd_Req,
  input  logic                         Rx_Drop,
  output logic [7:0]                   Rd_Data,
  output logic                         Rd_Valid,
  output logic                         Rx_Ready,
  output logic [$clog2(BUF_DEPTH):0]   Rx_FrameSize,
  output logic                         Rx_Overflow,
  output logic                         Rx_AbortedFrame,
  output logic                         Rx_FrameError,
  output logic                         Rx_Lost
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(BUF_DEPTH);
  localparam logic [PW-1:0] FCS_P   = PW'(FCS_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   size_q, size_d;
  logic [1:0]      lo_cnt_q, lo_cnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ready_q, ready_d;
  logic            ovf_q, ovf_d;
  logic            abt_q, abt_d;
  logic            ferr_q, ferr_d;
  logic            lost_q, lost_d;
  logic            vf_q;
  logic            wr_en;

  logic [7:0]      mem [BUF_DEPTH];

  logic            vf_rise;
  logic            wr_room;
  logic [PW-1:0]   wr_cnt;
  logic            rd_last;

  assign vf_rise = Rx_ValidFrame & ~vf_q;
  assign wr_room = (wr_ptr_q < DEPTH_P);
  // Stored byte count including a byte written in the same cycle as Rx_EoF.
  assign wr_cnt  = wr_ptr_q + PW'(Rx_WrBuff & wr_room);
  assign rd_last = (rd_ptr_q == (size_q - PW'(1)));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    size_d     = size_q;
    lo_cnt_d   = lo_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ready_d    = ready_q;
    ovf_d      = ovf_q;
    abt_d      = abt_q;
    ferr_d     = ferr_q;
    lost_d     = lost_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vf_rise) begin
          state_d  = ST_RECV;
          wr_ptr_d = '0;
          lo_cnt_d = '0;
          ovf_d    = 1'b0;
          abt_d    = 1'b0;
          ferr_d   = 1'b0;
          lost_d   = 1'b0;
        end
      end

      ST_RECV: begin
        if (Rx_WrBuff) begin
          if (wr_room) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end

        // Cycles spent with Rx_ValidFrame low; a late EoF/abort is still
        // honoured for a short grace period before the frame is abandoned.
        if (Rx_ValidFrame) lo_cnt_d = '0;
        else               lo_cnt_d = lo_cnt_q + 2'd1;

        if (Rx_AbortSignal) begin
          state_d = ST_IDLE;
          abt_d   = 1'b1;
        end else if (Rx_EoF) begin
          if (Rx_FCSerr || (wr_cnt <= FCS_P)) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end else begin
            state_d  = ST_HOLD;
            size_d   = wr_cnt - FCS_P;
            rd_ptr_d = '0;
            ready_d  = 1'b1;
          end
        end else if (!Rx_ValidFrame && (lo_cnt_q == 2'd2)) begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (vf_rise) lost_d = 1'b1;

        if (Rx_Drop) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end else if (Rd_Req && (rd_ptr_q < size_q)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d   = rd_ptr_q + PW'(1);
          if (rd_last) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      size_q     <= '0;
      lo_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      abt_q      <= 1'b0;
      ferr_q     <= 1'b0;
      lost_q     <= 1'b0;
      // Treat the line as already in a frame so a frame that was in progress
      // across reset is not picked up half-way; a fresh rising edge is needed.
      vf_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      size_q     <= size_d;
      lo_cnt_q   <= lo_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      abt_q      <= abt_d;
      ferr_q     <= ferr_d;
      lost_q     <= lost_d;
      vf_q       <= Rx_ValidFrame;
    end
  end

  // Frame buffer: no reset, contents are only meaningful below wr_ptr.
  always_ff @(posedge Clk) begin
    if (wr_en && !Rst) mem[wr_ptr_q[AW-1:0]] <= Rx_Data;
  end

  assign Rd_Data         = rd_data_q;
  assign Rd_Valid        = rd_valid_q;
  assign Rx_Ready        = ready_q;
  assign Rx_FrameSize    = size_q;
  assign Rx_Overflow     = ovf_q;
  assign Rx_AbortedFrame = abt_q;
  assign Rx_FrameError   = ferr_q;
  assign Rx_Lost         = lost_q;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_frame_ctrl
//
// Directed and randomized frames for hdlc_rx_frame_ctrl. A frame-level model
// decides the outcome of each frame (held / error / aborted / lost, overflow,
// payload size) from the frame's byte count and flags, and queues the payload
// bytes the CPU should read back.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_frame_ctrl;

  localparam int BUF_DEPTH = 128;
  localparam int FCS_BYTES = 2;
  localparam int PW        = $clog2(BUF_DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic          Rx_ValidFrame = 1'b0;
  logic          Rx_WrBuff = 1'b0;
  logic [7:0]    Rx_Data = 8'h00;
  logic          Rx_EoF = 1'b0;
  logic          Rx_AbortSignal = 1'b0;
  logic          Rx_FCSerr = 1'b0;
  logic          Rd_Req = 1'b0;
  logic          Rx_Drop = 1'b0;
  logic [7:0]    Rd_Data;
  logic          Rd_Valid;
  logic          Rx_Ready;
  logic [PW-1:0] Rx_FrameSize;
  logic          Rx_Overflow;
  logic          Rx_AbortedFrame;
  logic          Rx_FrameError;
  logic          Rx_Lost;

  hdlc_rx_frame_ctrl #(.BUF_DEPTH(BUF_DEPTH), .FCS_BYTES(FCS_BYTES)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff), .Rx_Data(Rx_Data),
    .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal), .Rx_FCSerr(Rx_FCSerr),
    .Rd_Req(Rd_Req), .Rx_Drop(Rx_Drop),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rx_Ready(Rx_Ready),
    .Rx_FrameSize(Rx_FrameSize), .Rx_Overflow(Rx_Overflow),
    .Rx_AbortedFrame(Rx_AbortedFrame), .Rx_FrameError(Rx_FrameError),
    .Rx_Lost(Rx_Lost)
  );

  // ---------------- scoreboard / model state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fb [0:255];
  bit         exp_ready, exp_ovf, exp_abt, exp_ferr, exp_lost;
  int         exp_size = 0;
  logic [7:0] last_rd = 8'h00;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_ready"}, 32'(Rx_Ready),        32'(exp_ready));
    chk({tag, "_size"},  32'(Rx_FrameSize),    32'(exp_size));
    chk({tag, "_ovf"},   32'(Rx_Overflow),     32'(exp_ovf));
    chk({tag, "_abt"},   32'(Rx_AbortedFrame), 32'(exp_abt));
    chk({tag, "_ferr"},  32'(Rx_FrameError),   32'(exp_ferr));
    chk({tag, "_lost"},  32'(Rx_Lost),         32'(exp_lost));
  endtask

  // Frame-level outcome from byte count and flags.
  task automatic model_frame(input int n, input bit fcserr, input bit abrt, input int abrt_at);
    int stored;
    int sz;
    exp_ready = 0; exp_ovf = 0; exp_abt = 0; exp_ferr = 0; exp_lost = 0;
    if (abrt) begin
      exp_abt = 1;
      exp_ovf = (abrt_at > BUF_DEPTH);
    end else begin
      stored  = (n > BUF_DEPTH) ? BUF_DEPTH : n;
      exp_ovf = (n > BUF_DEPTH);
      sz      = stored - FCS_BYTES;
      if (fcserr || sz <= 0) begin
        exp_ferr = 1;
      end else begin
        exp_ready = 1;
        exp_size  = sz;
        for (int i = 0; i < sz; i++) exp_q.push_back(fb[i]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int n, input bit fcserr, input bit abrt,
                            input int abrt_at, input bit abrt_eof, input bit eof_last);
    bit done;
    done = 0;
    Rx_ValidFrame = 1'b0; cyc();
    Rx_ValidFrame = 1'b1; cyc();
    for (int i = 0; i < n && !done; i++) begin
      if (abrt && i == abrt_at) begin
        Rx_AbortSignal = 1'b1; Rx_EoF = abrt_eof; cyc();
        Rx_AbortSignal = 1'b0; Rx_EoF = 1'b0;
        done = 1;
      end else begin
        if ($urandom_range(0, 3) == 0) cyc();
        Rx_WrBuff = 1'b1; Rx_Data = fb[i];
        if (!abrt && eof_last && i == n - 1) begin
          Rx_EoF = 1'b1; Rx_FCSerr = fcserr; done = 1;
        end
        cyc();
        Rx_WrBuff = 1'b0; Rx_EoF = 1'b0; Rx_FCSerr = 1'b0;
      end
    end
    if (!done) begin
      if (abrt) begin
        Rx_AbortSignal = 1'b1; Rx_EoF = abrt_eof;
      end else begin
        Rx_EoF = 1'b1; Rx_FCSerr = fcserr;
      end
      cyc();
      Rx_AbortSignal = 1'b0; Rx_EoF = 1'b0; Rx_FCSerr = 1'b0;
    end
    Rx_ValidFrame = 1'b0;
  endtask

  task automatic read_bytes(input int k);
    logic [7:0] e;
    for (int j = 0; j < k; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        Rd_Req = 1'b0; cyc();
        chk("rd_gap_valid", 32'(Rd_Valid), 32'(0));
      end
      Rd_Req = 1'b1; cyc();
      Rd_Req = 1'b0;
      e = exp_q.pop_front();
      chk("rd_valid", 32'(Rd_Valid), 32'(1));
      chk("rd_data",  32'(Rd_Data),  32'(e));
      last_rd = e;
    end
  endtask

  task automatic no_read(input string tag);
    Rd_Req = 1'b1; cyc();
    Rd_Req = 1'b0;
    chk({tag, "_no_valid"}, 32'(Rd_Valid), 32'(0));
    chk({tag, "_data_hold"}, 32'(Rd_Data), 32'(last_rd));
  endtask

  task automatic read_all(input string tag);
    read_bytes(exp_q.size());
    cyc();
    exp_ready = 0;
    chk({tag, "_ready_after"}, 32'(Rx_Ready), 32'(0));
    no_read({tag, "_extra"});
  endtask

  task automatic drop_with_req(input string tag);
    Rx_Drop = 1'b1; Rd_Req = 1'b1; cyc();
    Rx_Drop = 1'b0; Rd_Req = 1'b0;
    chk({tag, "_no_valid"}, 32'(Rd_Valid), 32'(0));
    cyc();
    exp_ready = 0;
    exp_q.delete();
    chk({tag, "_ready"}, 32'(Rx_Ready), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, k;
    bit fe, ab, ae, el;
    int aat;

    // Reset
    Rst = 1'b1;
    repeat (3) cyc();
    Rst = 1'b0;
    exp_ready = 0; exp_ovf = 0; exp_abt = 0; exp_ferr = 0; exp_lost = 0;
    exp_size = 0;
    check_status("reset");
    chk("reset_rd_valid", 32'(Rd_Valid), 32'(0));
    chk("reset_rd_data",  32'(Rd_Data),  32'(0));
    cyc();

    // 10-byte good frame, 8 payload bytes read back
    for (int i = 0; i < 10; i++) fb[i] = 8'(i + 1);
    model_frame(10, 0, 0, 0);
    send_frame(10, 0, 0, 0, 0, 1);
    check_status("f10");
    read_all("f10");

    // Abort together with EoF after 5 bytes
    for (int i = 0; i < 5; i++) fb[i] = 8'(8'h40 + i);
    model_frame(5, 0, 1, 5);
    send_frame(5, 0, 1, 5, 1, 0);
    check_status("abort");
    no_read("abort");

    // 130 bytes: overflow, 126-byte payload
    for (int i = 0; i < 130; i++) fb[i] = 8'(i * 3 + 7);
    model_frame(130, 0, 0, 0);
    send_frame(130, 0, 0, 0, 0, 0);
    check_status("ovf");
    read_all("ovf");

    // Too short, then FCS error
    fb[0] = 8'hA1; fb[1] = 8'hA2;
    model_frame(2, 0, 0, 0);
    send_frame(2, 0, 0, 0, 0, 1);
    check_status("short");
    no_read("short");
    for (int i = 0; i < 6; i++) fb[i] = 8'(8'hB0 + i);
    model_frame(6, 1, 0, 0);
    send_frame(6, 1, 0, 0, 0, 0);
    check_status("fcserr");

    // Rx_ValidFrame falls with no EoF: frame abandoned silently
    Rx_ValidFrame = 1'b0; cyc();
    Rx_ValidFrame = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      Rx_WrBuff = 1'b1; Rx_Data = 8'(8'hC0 + i); cyc();
    end
    Rx_WrBuff = 1'b0; Rx_ValidFrame = 1'b0;
    repeat (5) cyc();
    exp_ready = 0; exp_ovf = 0; exp_abt = 0; exp_ferr = 0; exp_lost = 0;
    check_status("timeout");

    // Held 4-byte payload, second frame arrives and is lost
    for (int i = 0; i < 6; i++) fb[i] = 8'(8'h10 + i);
    model_frame(6, 0, 0, 0);
    send_frame(6, 0, 0, 0, 0, 1);
    check_status("held");
    for (int i = 0; i < 6; i++) fb[i] = 8'hEE;
    send_frame(6, 0, 0, 0, 0, 1);
    exp_lost = 1;
    check_status("lost");
    read_bytes(3);
    drop_with_req("drop");

    // Reset during reception after 3 bytes
    Rx_ValidFrame = 1'b0; cyc();
    Rx_ValidFrame = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      Rx_WrBuff = 1'b1; Rx_Data = 8'(8'hD0 + i); cyc();
    end
    Rx_WrBuff = 1'b0;
    Rst = 1'b1; Rd_Req = 1'b1; cyc();
    Rst = 1'b0; Rd_Req = 1'b0;
    exp_ready = 0; exp_ovf = 0; exp_abt = 0; exp_ferr = 0; exp_lost = 0;
    exp_size = 0; last_rd = 8'h00;
    check_status("rst_recv");
    chk("rst_recv_rd_valid", 32'(Rd_Valid), 32'(0));
    chk("rst_recv_rd_data",  32'(Rd_Data),  32'(0));
    cyc();
    chk("rst_recv_no_valid", 32'(Rd_Valid), 32'(0));
    Rx_ValidFrame = 1'b0; cyc();
    for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    model_frame(12, 0, 0, 0);
    send_frame(12, 0, 0, 0, 0, $urandom_range(0, 1) == 1);
    check_status("post_rst");
    read_all("post_rst");

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(0, 4);
        1:       n = $urandom_range(126, 140);
        default: n = $urandom_range(5, 40);
      endcase
      fe  = ($urandom_range(0, 4) == 0);
      ab  = ($urandom_range(0, 5) == 0);
      aat = $urandom_range(0, n);
      ae  = ($urandom_range(0, 1) == 1);
      el  = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      model_frame(n, fe, ab, aat);
      send_frame(n, fe, ab, aat, ae, el);
      check_status("rand");
      if (exp_ready) begin
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, exp_size - 1);
          read_bytes(k);
          drop_with_req("rand_drop");
        end else begin
          read_all("rand");
        end
      end else begin
        no_read("rand_none");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
